cube_frame_buffer: RTL
======================

// Module: cube_frame_buffer
// PURPOSE
//  Double-buffered 64-byte frame store directly upstream of the LED-cube frame driver.
//  A loader (UART/flash/pattern generator) streams one frame, 8 layers x 8 latch bytes,
//  into the back bank over a valid/ready byte interface.
//  The frame driver reads the front bank combinationally by 6-bit address.
//  Banks swap only on the driver's frame-boundary pulse, so a displayed frame never tears.
// PARAMETERS
//  FRAME_BYTES  64  bytes per frame (8 layers x 8 latches); must be a power of 2
//  ADDR_W       6   clog2(FRAME_BYTES); width of rd_addr and the write pointer
//  DATA_W       8   bits per byte (one LED per bit in a latch row)
//  CNT_W        8   width of frames_swapped counter
// PORTS
//  clk             in   1       system clock; every flop is on its rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  wr_valid        in   1       loader byte valid
//  wr_ready        out  1       buffer can accept a byte this cycle
//  wr_data         in   DATA_W  byte; address is implicit (sequential from 0)
//  wr_last         in   1       loader marks the final byte of a frame
//  frame_boundary  in   1       one-cycle pulse from driver; current frame is finished
//  rd_addr         in   ADDR_W  {layer[2:0], latch[2:0]} from driver
//  rd_data         out  DATA_W  front_bank[rd_addr]; combinational, zero latency
//  swap_pending    out  1       back bank is full and waiting for frame_boundary
//  frames_swapped  out  CNT_W   number of completed swaps, wraps modulo 2^CNT_W
//  err_len         out  1       sticky: wr_last did not coincide with byte FRAME_BYTES-1
//  err_clr         in   1       synchronous clear of err_len
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - both banks all zero, so the cube is dark; bank_sel=0, so bank0 is front
//  - wr_ptr=0, state=FILL, wr_ready=1, swap_pending=0, frames_swapped=0, err_len=0
//  - reset mid-fill discards the partial frame entirely
//  FSM states: FILL, FULL.
//  - FILL: wr_ready=1. A byte is accepted when wr_valid&&wr_ready.
//    - Accept: back[wr_ptr]<=wr_data, then wr_ptr++.
//    - Accepting at wr_ptr==FRAME_BYTES-1: wr_ptr->0 and the FSM goes to FULL next cycle.
//  - FILL, wr_last accepted with wr_ptr!=FRAME_BYTES-1:
//    - frame is discarded, wr_ptr->0, err_len<=1, the FSM stays in FILL
//    - back bank keeps stale bytes; these are overwritten by the next frame
//  - Byte FRAME_BYTES-1 accepted without wr_last: the frame is still accepted and err_len<=1.
//  - FULL: wr_ready=0, swap_pending=1.
//    - On frame_boundary: bank_sel toggles, frames_swapped++, the FSM returns to FILL.
//    - The new front is visible on rd_data in the cycle after the pulse.
//  - frame_boundary while in FILL is ignored; the front bank repeats.
//  - frame_boundary in the same cycle as the final byte is not a swap.
//    FULL must be registered first, so the swap waits for the next boundary.
//  - err_clr and a new error in the same cycle: the error wins, err_len=1.
//  rd_data always reads front = bank[bank_sel]. Writes never target the front bank.
//  Writes and reads in the same cycle are independent.
//  wr_ptr and frames_swapped wrap naturally. No saturation.
// STRUCTURE
//  cube_pkg:
//  - localparams FRAME_BYTES, ADDR_W, DATA_W
//  - typedef logic [DATA_W-1:0] cube_byte_t
//  - enum fb_state_e {FILL, FULL}
//  Sub-module cube_frame_bank:
//  - FRAME_BYTES x DATA_W flop array with async reset, one write port, async read
//  - instantiated twice
//  - each bank's we = accept && (bank_sel != own index)
//  Top level holds the FSM, wr_ptr, bank_sel, counters and error flag.
// TESTING
//  1 Reset then rd_addr sweep 0..63
//    -> rd_data=8'h00 everywhere; wr_ready=1; swap_pending=0; frames_swapped=0.
//  2 Stream 64 bytes 8'h00..8'h3F, wr_last on byte 63, then boundary pulse
//    -> swap_pending=1 after the last byte
//    -> rd_data still 0 until the pulse
//    -> after the pulse rd_data[a]==a and frames_swapped=1.
//  3 Hold frame_boundary low after a full load, keep wr_valid=1
//    -> wr_ready stays 0, nothing is written, and the front bank is unchanged.
//  4 wr_last on byte index 10
//    -> err_len=1, wr_ptr back to 0, no swap on the next boundary
//    -> err_clr clears err_len.
//  5 Final byte and frame_boundary in the same cycle
//    -> no swap; a swap on the next pulse; frames_swapped increments once.
//  6 Assert rst_n=0 mid-frame (byte 30), no clock edge needed
//    -> all outputs at reset values at once; the reload of a full frame works as in 2.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared sizes, byte type and FSM state encoding for the LED-cube frame buffer.
package cube_pkg;

    localparam int unsigned FRAME_BYTES = 64;
    localparam int unsigned ADDR_W      = $clog2(FRAME_BYTES);
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 8;

    typedef logic [DATA_W-1:0] cube_byte_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fb_state_e;

endpackage

// File: rtl/cube_frame_buffer_if.sv
// Loader-to-buffer byte stream: valid/ready handshake with an end-of-frame marker.
interface cube_frame_buffer_if;
    import cube_pkg::*;

    logic       wr_valid;
    logic       wr_ready;
    cube_byte_t wr_data;
    logic       wr_last;

    modport master (output wr_valid, output wr_data, output wr_last, input wr_ready);
    modport slave  (input wr_valid, input wr_data, input wr_last, output wr_ready);

endinterface

// File: rtl/cube_frame_bank.sv
// One frame of latch bytes: flop array, single write port, zero-latency read port.
module cube_frame_bank
    import cube_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  cube_byte_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output cube_byte_t        rdata_c
);

    cube_byte_t mem [FRAME_BYTES];

    // Reset clears the whole frame so the cube comes up dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/cube_frame_buffer.sv
// Double-buffered 64-byte frame store; the loader fills the back bank while the
// driver reads the front bank, and the banks swap only on a driver frame boundary.
module cube_frame_buffer
    import cube_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    cube_frame_buffer_if.slave  wr,
    input  logic                frame_boundary,
    input  logic [ADDR_W-1:0]   rd_addr,
    output cube_byte_t          rd_data,
    output logic                swap_pending,
    output logic [CNT_W-1:0]    frames_swapped,
    output logic                err_len,
    input  logic                err_clr
);

    fb_state_e         state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              bank_sel;
    logic              accept_c;
    logic              at_end_c;
    logic              err_set_c;
    cube_byte_t        rdata0_c;
    cube_byte_t        rdata1_c;

    assign accept_c  = wr.wr_valid && wr.wr_ready;
    assign at_end_c  = (wr_ptr == ADDR_W'(FRAME_BYTES - 1));
    // Error: last marker on the wrong byte, or the final byte arrives unmarked.
    assign err_set_c = accept_c && (at_end_c ? !wr.wr_last : wr.wr_last);

    // Fill/swap FSM with write pointer, bank select and swap counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= FILL;
            wr_ptr         <= '0;
            bank_sel       <= 1'b0;
            wr.wr_ready    <= 1'b1;
            swap_pending   <= 1'b0;
            frames_swapped <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept_c) begin
                        if (at_end_c) begin
                            wr_ptr       <= '0;
                            state        <= FULL;
                            wr.wr_ready  <= 1'b0;
                            swap_pending <= 1'b1;
                        end else if (wr.wr_last) begin
                            wr_ptr <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                        end
                    end
                end
                FULL: begin
                    if (frame_boundary) begin
                        bank_sel       <= ~bank_sel;
                        frames_swapped <= frames_swapped + CNT_W'(1);
                        state          <= FILL;
                        wr.wr_ready    <= 1'b1;
                        swap_pending   <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    // Sticky length error; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else if (err_set_c) begin
            err_len <= 1'b1;
        end else if (err_clr) begin
            err_len <= 1'b0;
        end
    end

    cube_frame_bank u_bank0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept_c && bank_sel),
        .waddr   (wr_ptr),
        .wdata   (wr.wr_data),
        .raddr   (rd_addr),
        .rdata_c (rdata0_c)
    );

    cube_frame_bank u_bank1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept_c && !bank_sel),
        .waddr   (wr_ptr),
        .wdata   (wr.wr_data),
        .raddr   (rd_addr),
        .rdata_c (rdata1_c)
    );

    assign rd_data = bank_sel ? rdata1_c : rdata0_c;

endmodule
